// File: rtl/mux_pkg.sv
// Shared constants and elaboration helpers for the pipelined radix-4 word mux tree.
package mux_pkg;

  localparam int MAX_SEL_W = 8;

  // Number of radix-4 levels needed to resolve a select of width sel_w.
  function automatic int levels(input int sel_w);
    return sel_w / 2;
  endfunction

  // Legal select widths: even, 2..MAX_SEL_W.
  function automatic bit sel_w_ok(input int sel_w);
    return (sel_w >= 2) && (sel_w <= MAX_SEL_W) && ((sel_w % 2) == 0);
  endfunction

endpackage

// File: rtl/mux_4w.sv
// Combinational 4:1 word multiplexer; one leaf of a mux-tree level.
module mux_4w #(
  parameter int WIDTH = 32
) (
  input  logic [4*WIDTH-1:0] d_i,
  input  logic [1:0]         sel_i,
  output logic [WIDTH-1:0]   y_o
);

  always_comb begin
    y_o = d_i[0 +: WIDTH];
    case (sel_i)
      2'd0: y_o = d_i[0*WIDTH +: WIDTH];
      2'd1: y_o = d_i[1*WIDTH +: WIDTH];
      2'd2: y_o = d_i[2*WIDTH +: WIDTH];
      2'd3: y_o = d_i[3*WIDTH +: WIDTH];
      default: y_o = d_i[0 +: WIDTH];
    endcase
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 word mux: SEL_W/2 radix-4 levels, each followed by a register stage
// carrying surviving words, leftover select bits, tag and valid; supports stall and flush.
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4,
  parameter int TAG_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(2**SEL_W)*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_valid,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic                        stall,
  input  logic                        flush,
  output logic [WIDTH-1:0]            out_data,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        out_valid
);

  localparam int N      = 2**SEL_W;
  localparam int LEVELS = levels(SEL_W);

  if (!sel_w_ok(SEL_W)) begin : g_bad_sel_w
    $error("mux_tree_pipe: SEL_W=%0d must be even and within 2..%0d", SEL_W, MAX_SEL_W);
  end

  // Payload registers only move when the stage advances and the incoming entry is live,
  // so the output word survives bubbles and flushes.
  logic adv;
  assign adv = ~stall & ~flush;

  genvar gi, gj;
  for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
    localparam int NIN  = N >> (2*gi);
    localparam int NOUT = NIN / 4;
    localparam int SIN  = SEL_W - 2*gi;

    logic [NIN*WIDTH-1:0]  data_in;
    logic [SIN-1:0]        sel_in;
    logic [TAG_W-1:0]      tag_in;
    logic                  valid_in;

    logic [NOUT*WIDTH-1:0] data_d;
    logic [NOUT*WIDTH-1:0] data_q;
    logic [TAG_W-1:0]      tag_q;
    logic                  valid_d;
    logic                  valid_q;
    logic                  load;

    if (gi == 0) begin : g_src
      assign data_in  = in_data;
      assign sel_in   = in_sel;
      assign tag_in   = in_tag;
      assign valid_in = in_valid;
    end else begin : g_src
      assign data_in  = g_lvl[gi-1].data_q;
      assign sel_in   = g_lvl[gi-1].g_fwd.sel_q;
      assign tag_in   = g_lvl[gi-1].tag_q;
      assign valid_in = g_lvl[gi-1].valid_q;
    end

    for (gj = 0; gj < NOUT; gj++) begin : g_mux
      mux_4w #(.WIDTH(WIDTH)) u_mux (
        .d_i   (data_in[gj*4*WIDTH +: 4*WIDTH]),
        .sel_i (sel_in[1:0]),
        .y_o   (data_d[gj*WIDTH +: WIDTH])
      );
    end

    assign load = adv & valid_in;

    always_comb begin
      valid_d = valid_q;
      if (flush) begin
        valid_d = 1'b0;
      end else if (!stall) begin
        valid_d = valid_in;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
        tag_q  <= '0;
      end else if (load) begin
        data_q <= data_d;
        tag_q  <= tag_in;
      end
    end

    // Select bits still needed by later levels; the last level consumes all of them.
    if (gi < LEVELS - 1) begin : g_fwd
      logic [SIN-3:0] sel_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          sel_q <= '0;
        end else if (load) begin
          sel_q <= sel_in[SIN-1:2];
        end
      end
    end
  end

  assign out_data  = g_lvl[LEVELS-1].data_q;
  assign out_tag   = g_lvl[LEVELS-1].tag_q;
  assign out_valid = g_lvl[LEVELS-1].valid_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe (default parameters): directed tables plus
// randomized traffic compared against an entry-level pipeline reference model.
module tb_mux_tree_pipe;

  localparam int WIDTH = 32;
  localparam int SEL_W = 4;
  localparam int TAG_W = 5;
  localparam int N     = 2**SEL_W;
  localparam int L     = SEL_W / 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N*WIDTH-1:0]   in_data = '0;
  logic [SEL_W-1:0]     in_sel = '0;
  logic                 in_valid = 1'b0;
  logic [TAG_W-1:0]     in_tag = '0;
  logic                 stall = 1'b0;
  logic                 flush = 1'b0;
  logic [WIDTH-1:0]     out_data;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_valid;

  always #5 clk = ~clk;

  mux_tree_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_tag    (in_tag),
    .stall     (stall),
    .flush     (flush),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_valid (out_valid)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: ordered slots of in-flight entries, word chosen directly by index.
  typedef struct {
    bit               v;
    logic [WIDTH-1:0] d;
    logic [TAG_W-1:0] t;
  } entry_t;

  entry_t           m_pipe [L];
  logic [WIDTH-1:0] m_out_d = '0;
  logic [TAG_W-1:0] m_out_t = '0;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] exp_data;
    logic [TAG_W-1:0] exp_tag;
  } vec_t;

  typedef struct {
    bit               r;
    bit               f;
    bit               s;
    bit               iv;
    logic [SEL_W-1:0] sel;
    bit               ev;
    logic [WIDTH-1:0] ed;
  } seq_t;

  vec_t sweep [16];
  seq_t seq [$];

  function automatic seq_t mk(bit r, bit f, bit s, bit iv, int sel, bit ev, logic [WIDTH-1:0] ed);
    seq_t x;
    x.r = r; x.f = f; x.s = s; x.iv = iv; x.sel = SEL_W'(sel); x.ev = ev; x.ed = ed;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < L; i++) m_pipe[i] = '{v: 1'b0, d: '0, t: '0};
      m_out_d = '0;
      m_out_t = '0;
    end else if (flush) begin
      for (int i = 0; i < L; i++) m_pipe[i].v = 1'b0;
    end else if (!stall) begin
      for (int i = L - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0].v = in_valid;
      m_pipe[0].d = in_data[int'(in_sel)*WIDTH +: WIDTH];
      m_pipe[0].t = in_tag;
      if (m_pipe[L-1].v) begin
        m_out_d = m_pipe[L-1].d;
        m_out_t = m_pipe[L-1].t;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("model_out_valid", 64'(out_valid), 64'(m_pipe[L-1].v));
    chk("model_out_data", 64'(out_data), 64'(m_out_d));
    chk("model_out_tag", 64'(out_tag), 64'(m_out_t));
  endtask

  task automatic drive(input bit r, input bit f, input bit s, input bit iv,
                       input logic [SEL_W-1:0] sel, input logic [TAG_W-1:0] tag);
    rst = r; flush = f; stall = s; in_valid = iv; in_sel = sel; in_tag = tag;
  endtask

  task automatic default_data();
    for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = 32'hA000_0000 + 32'(k);
  endtask

  initial begin
    for (int i = 0; i < L; i++) m_pipe[i] = '{v: 1'b0, d: '0, t: '0};
    for (int k = 0; k < 16; k++) begin
      sweep[k].sel      = SEL_W'(k);
      sweep[k].tag      = TAG_W'(k);
      sweep[k].exp_data = 32'hA000_0000 + 32'(k);
      sweep[k].exp_tag  = TAG_W'(k);
    end
    // Stall: 9 leaves 3 cycles later than it would unstalled.
    seq.push_back(mk(1,0,0,0, 0, 0, 32'h0));
    seq.push_back(mk(0,0,0,1, 5, 0, 32'h0));
    seq.push_back(mk(0,0,0,1, 9, 1, 32'hA000_0005));
    seq.push_back(mk(0,0,1,0, 0, 1, 32'hA000_0005));
    seq.push_back(mk(0,0,1,0, 0, 1, 32'hA000_0005));
    seq.push_back(mk(0,0,1,0, 0, 1, 32'hA000_0005));
    seq.push_back(mk(0,0,0,0, 0, 1, 32'hA000_0009));
    seq.push_back(mk(0,0,0,0, 0, 0, 32'hA000_0009));
    // Flush: in-flight 3 and the concurrently presented 12 both vanish.
    seq.push_back(mk(1,0,0,0, 0, 0, 32'h0));
    seq.push_back(mk(0,0,0,1, 1, 0, 32'h0));
    seq.push_back(mk(0,0,0,0, 0, 1, 32'hA000_0001));
    seq.push_back(mk(0,0,0,0, 0, 0, 32'hA000_0001));
    seq.push_back(mk(0,0,0,1, 3, 0, 32'hA000_0001));
    seq.push_back(mk(0,1,1,1, 12, 0, 32'hA000_0001));
    seq.push_back(mk(0,0,0,0, 0, 0, 32'hA000_0001));
    seq.push_back(mk(0,0,0,0, 0, 0, 32'hA000_0001));
    // Bubble hold: single-cycle valid pulse, word held afterwards.
    seq.push_back(mk(1,0,0,0, 0, 0, 32'h0));
    seq.push_back(mk(0,0,0,1, 2, 0, 32'h0));
    seq.push_back(mk(0,0,0,0, 0, 1, 32'hA000_0002));
    seq.push_back(mk(0,0,0,0, 0, 0, 32'hA000_0002));
    seq.push_back(mk(0,0,0,0, 0, 0, 32'hA000_0002));
    seq.push_back(mk(0,0,0,0, 0, 0, 32'hA000_0002));
    seq.push_back(mk(0,0,0,0, 0, 0, 32'hA000_0002));
    // Reset mid-stream drops both entries and the one presented with it.
    seq.push_back(mk(1,0,0,0, 0, 0, 32'h0));
    seq.push_back(mk(0,0,0,1, 4, 0, 32'h0));
    seq.push_back(mk(0,0,0,1, 6, 1, 32'hA000_0004));
    seq.push_back(mk(1,0,0,1, 8, 0, 32'h0));
    seq.push_back(mk(0,0,0,0, 0, 0, 32'h0));
    seq.push_back(mk(0,0,0,0, 0, 0, 32'h0));
    seq.push_back(mk(0,0,0,0, 0, 0, 32'h0));

    default_data();

    // Reset state.
    drive(1, 0, 0, 0, '0, '0);
    tick();
    tick();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    $display("reset: out_valid=%0d out_data=%h out_tag=%0d", out_valid, out_data, out_tag);

    // Sweep: back-to-back selections, each emerging L cycles after presentation.
    for (int i = 0; i < 16 + L; i++) begin
      if (i < 16) drive(0, 0, 0, 1, sweep[i].sel, sweep[i].tag);
      else        drive(0, 0, 0, 0, '0, '0);
      tick();
      if (i >= L - 1 && i - (L - 1) < 16) begin
        int j;
        j = i - (L - 1);
        chk("sweep_valid", 64'(out_valid), 64'd1);
        chk("sweep_data", 64'(out_data), 64'(sweep[j].exp_data));
        chk("sweep_tag", 64'(out_tag), 64'(sweep[j].exp_tag));
        $display("sweep %0d: out_valid=%0d out_data=%h out_tag=%0d", j, out_valid, out_data, out_tag);
      end
    end
    chk("sweep_drain_valid", 64'(out_valid), 64'd0);

    // Hand-written multi-cycle sequences.
    foreach (seq[i]) begin
      drive(seq[i].r, seq[i].f, seq[i].s, seq[i].iv, seq[i].sel, TAG_W'(seq[i].sel));
      tick();
      chk("seq_valid", 64'(out_valid), 64'(seq[i].ev));
      chk("seq_data", 64'(out_data), 64'(seq[i].ed));
      chk("seq_tag", 64'(out_tag), 64'(seq[i].ed[TAG_W-1:0]));
      $display("seq %0d: rst=%0d flush=%0d stall=%0d in_valid=%0d sel=%0d -> out_valid=%0d out_data=%h",
               i, seq[i].r, seq[i].f, seq[i].s, seq[i].iv, seq[i].sel, out_valid, out_data);
    end

    // Randomized traffic with stall, flush and occasional reset.
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = $urandom;
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
            SEL_W'($urandom_range(0, N - 1)), TAG_W'($urandom));
      tick();
    end
    $display("random: %0d cycles compared against model", 10000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
